// File: rtl/step_scheduler_if.sv
// step_scheduler_if
// Bundles the step_scheduler's control, status and pattern-memory signals.
//   slave  : used by the scheduler. It receives the controls and pat_data, and
//            drives the read strobe/address, triggers and status.
//   master : used by the surrounding board logic or a testbench.
// Signals:
//   play, stop              single-cycle user control pulses
//   step_period[PW]         cycles between triggers (clamped to at least 4)
//   last_step[SW_IDX]       final active step index
//   mute[NUM_TRACKS]        per-track trigger suppression
//   pat_rd, pat_addr        pattern memory read strobe and address
//   pat_data[NUM_TRACKS]    pattern word, valid the cycle after pat_rd
//   trig[NUM_TRACKS]        one-cycle trigger pulses
//   step_tick               one-cycle pulse on each trigger update
//   step_idx[SW_IDX]        current step for display
//   running                 playback active
interface step_scheduler_if #(
    parameter int SW_IDX     = 4,
    parameter int NUM_TRACKS = 4,
    parameter int PW         = 26
);
    logic                  play;
    logic                  stop;
    logic [PW-1:0]         step_period;
    logic [SW_IDX-1:0]     last_step;
    logic [NUM_TRACKS-1:0] mute;
    logic                  pat_rd;
    logic [SW_IDX-1:0]     pat_addr;
    logic [NUM_TRACKS-1:0] pat_data;
    logic [NUM_TRACKS-1:0] trig;
    logic                  step_tick;
    logic [SW_IDX-1:0]     step_idx;
    logic                  running;

    modport slave (
        input  play, stop, step_period, last_step, mute, pat_data,
        output pat_rd, pat_addr, trig, step_tick, step_idx, running
    );

    modport master (
        output play, stop, step_period, last_step, mute, pat_data,
        input  pat_rd, pat_addr, trig, step_tick, step_idx, running
    );
endinterface

// File: rtl/step_scheduler.sv
// step_scheduler
// Playback controller for the step sequencer. It runs a tempo counter and
// walks a step index through pattern memory. For each step it fetches the
// step's track bits over a one-cycle-latency read port, then emits
// one-cycle trigger pulses per track.
// Ports:
//   CLOCK_50  system clock
//   reset     asynchronous active-high reset; clears all state
//   bus       step_scheduler_if.slave (controls, pattern port, triggers, status)
// Each step spends FETCH (1 cycle), LATCH (1 cycle) and COUNT (P-2 cycles).
// Triggers are therefore exactly P = max(step_period, 4) cycles apart.
module step_scheduler #(
    parameter int NUM_STEPS  = 16,
    parameter int SW_IDX     = 4,
    parameter int NUM_TRACKS = 4,
    parameter int PW         = 26
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    step_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_COUNT = 2'd3
    } state_t;

    localparam logic [PW-1:0]     MIN_PERIOD = PW'(3'd4);
    localparam logic [SW_IDX-1:0] LAST_IDX   = SW_IDX'(NUM_STEPS - 1);

    state_t                state_r,     state_n;
    logic [SW_IDX-1:0]     step_idx_r,  step_idx_n;
    logic [PW-1:0]         cnt_r,       cnt_n;
    logic [NUM_TRACKS-1:0] trig_r,      trig_n;
    logic                  step_tick_r, step_tick_n;
    logic                  pat_rd_r,    pat_rd_n;
    logic                  running_r,   running_n;
    logic [PW-1:0]         eff_period_s;

    // Next-state, counter, step-advance and trigger computation.
    always_comb begin
        state_n      = state_r;
        step_idx_n   = step_idx_r;
        cnt_n        = cnt_r;
        trig_n       = {NUM_TRACKS{1'b0}};
        step_tick_n  = 1'b0;
        if (bus.step_period < MIN_PERIOD) begin
            eff_period_s = MIN_PERIOD;
        end else begin
            eff_period_s = bus.step_period;
        end

        if (bus.stop) begin
            // stop wins over everything, including a coincident play or an in-flight fetch
            state_n    = ST_IDLE;
            step_idx_n = {SW_IDX{1'b0}};
            cnt_n      = {PW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.play) begin
                        state_n = ST_FETCH;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_n = ST_LATCH;
                end
                ST_LATCH: begin
                    // FETCH and LATCH account for two cycles of the period, and
                    // COUNT runs from P-3 down to 0 inclusive.
                    state_n     = ST_COUNT;
                    trig_n      = bus.pat_data & ~bus.mute;
                    step_tick_n = 1'b1;
                    cnt_n       = eff_period_s - PW'(2'd3);
                end
                ST_COUNT: begin
                    if (cnt_r == {PW{1'b0}}) begin
                        state_n = ST_FETCH;
                        if ((step_idx_r >= bus.last_step) || (step_idx_r == LAST_IDX)) begin
                            step_idx_n = {SW_IDX{1'b0}};
                        end else begin
                            step_idx_n = step_idx_r + SW_IDX'(1'b1);
                        end
                    end else begin
                        cnt_n = cnt_r - PW'(1'b1);
                    end
                end
                default: begin
                    state_n    = ST_IDLE;
                    step_idx_n = {SW_IDX{1'b0}};
                    cnt_n      = {PW{1'b0}};
                end
            endcase
        end

        pat_rd_n  = (state_n == ST_FETCH);
        running_n = (state_n != ST_IDLE);
    end

    // State and registered outputs with asynchronous clear.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            step_idx_r  <= {SW_IDX{1'b0}};
            cnt_r       <= {PW{1'b0}};
            trig_r      <= {NUM_TRACKS{1'b0}};
            step_tick_r <= 1'b0;
            pat_rd_r    <= 1'b0;
            running_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            step_idx_r  <= step_idx_n;
            cnt_r       <= cnt_n;
            trig_r      <= trig_n;
            step_tick_r <= step_tick_n;
            pat_rd_r    <= pat_rd_n;
            running_r   <= running_n;
        end
    end

    assign bus.pat_rd    = pat_rd_r;
    assign bus.pat_addr  = step_idx_r;
    assign bus.trig      = trig_r;
    assign bus.step_tick = step_tick_r;
    assign bus.step_idx  = step_idx_r;
    assign bus.running   = running_r;

endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler
// Directed and random stimulus for step_scheduler. A time-based reference
// model tracks playback as "next trigger time" plus "current step", and every
// cycle's outputs are compared against it.
module tb_step_scheduler;
    localparam int NUM_STEPS  = 16;
    localparam int SW_IDX     = 4;
    localparam int NUM_TRACKS = 4;
    localparam int PW         = 26;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    step_scheduler_if #(.SW_IDX(SW_IDX), .NUM_TRACKS(NUM_TRACKS), .PW(PW)) bus ();

    step_scheduler #(
        .NUM_STEPS(NUM_STEPS), .SW_IDX(SW_IDX), .NUM_TRACKS(NUM_TRACKS), .PW(PW)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .bus(bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Pattern RAM with one-cycle read latency.
    logic [NUM_TRACKS-1:0] mem [NUM_STEPS];
    always @(posedge CLOCK_50) begin
        if (bus.pat_rd) bus.pat_data <= mem[bus.pat_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state.
    longint cyc    = 0;
    bit     m_run  = 1'b0;
    int     m_step = 0;
    longint m_next = 0;
    logic [NUM_TRACKS-1:0] e_trig = '0;
    bit     e_tick = 1'b0;
    bit     e_rd   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Playback rules: a trigger fires 2 edges after play, then every P edges.
    // The step advances 2 edges before each following trigger.
    task automatic model_edge();
        int p;
        e_trig = '0;
        e_tick = 1'b0;
        if (reset) begin
            m_run  = 1'b0;
            m_step = 0;
        end else if (bus.stop) begin
            m_run  = 1'b0;
            m_step = 0;
        end else if (m_run) begin
            if (cyc == m_next) begin
                e_trig = mem[m_step] & ~bus.mute;
                e_tick = 1'b1;
                p = (bus.step_period < 4) ? 4 : int'(bus.step_period);
                m_next = cyc + p;
            end else if (cyc == m_next - 2) begin
                m_step = (m_step >= int'(bus.last_step)) ? 0 : m_step + 1;
            end
        end else if (bus.play) begin
            m_run  = 1'b1;
            m_next = cyc + 2;
        end
        e_rd = m_run && (cyc == m_next - 2);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        cyc++;
        model_edge();
        #1;
        chk("trig",      bus.trig,      e_trig);
        chk("step_tick", bus.step_tick, e_tick);
        chk("step_idx",  bus.step_idx,  m_step);
        chk("pat_addr",  bus.pat_addr,  m_step);
        chk("running",   bus.running,   m_run);
        chk("pat_rd",    bus.pat_rd,    e_rd);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_play();
        bus.play = 1'b1;
        tick();
        bus.play = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic wait_model_step(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (m_step != target && n < budget) begin
            tick();
            n++;
        end
        if (m_step != target) begin
            checks++;
            errors++;
            $error("FAIL %s timeout observed_step=%0d expected_step=%0d", tag, m_step, target);
        end
    endtask

    initial begin
        bus.play        = 1'b0;
        bus.stop        = 1'b0;
        bus.step_period = PW'(10);
        bus.last_step   = 4'd3;
        bus.mute        = 4'b0000;
        for (int i = 0; i < NUM_STEPS; i++) mem[i] = 4'b0000;

        // Reset then idle
        ticks(3);
        reset = 1'b0;
        ticks(100);

        // Basic playback
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
        pulse_play();
        ticks(2);
        chk("basic_latency_trig", bus.trig, 4'b0001);
        ticks(10);
        chk("basic_second_trig", bus.trig, 4'b0010);
        chk("basic_second_idx", bus.step_idx, 4'd1);
        ticks(30);
        chk("basic_wrap_trig", bus.trig, 4'b0001);
        chk("basic_wrap_idx", bus.step_idx, 4'd0);
        pulse_stop();
        chk("basic_stop_running", bus.running, 1'b0);

        // Clamp and mute
        for (int i = 0; i < NUM_STEPS; i++) mem[i] = 4'b1111;
        bus.step_period = PW'(1);
        bus.mute        = 4'b0001;
        bus.last_step   = 4'd15;
        pulse_play();
        ticks(2);
        chk("clamp_first_trig", bus.trig, 4'b1110);
        ticks(4);
        chk("clamp_next_trig", bus.trig, 4'b1110);
        chk("clamp_next_tick", bus.step_tick, 1'b1);
        ticks(20);
        pulse_stop();

        // Stop mid-step
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
        bus.step_period = PW'(10);
        bus.mute        = 4'b0000;
        bus.last_step   = 4'd3;
        pulse_play();
        wait_model_step(2, 100, "wait_step2");
        ticks(3);
        pulse_stop();
        chk("stop_running", bus.running, 1'b0);
        chk("stop_idx", bus.step_idx, 4'd0);
        ticks(20);
        pulse_play();
        ticks(2);
        chk("restart_trig", bus.trig, 4'b0001);
        ticks(5);
        pulse_stop();

        // Simultaneous play and stop, live last_step and period changes
        ticks(2);
        bus.play = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.play = 1'b0;
        bus.stop = 1'b0;
        chk("play_stop_idle", bus.running, 1'b0);
        ticks(3);
        for (int i = 0; i < NUM_STEPS; i++) mem[i] = 4'($urandom);
        bus.last_step = 4'd15;
        pulse_play();
        wait_model_step(5, 200, "wait_step5");
        ticks(3);
        bus.last_step = 4'd2;
        wait_model_step(0, 30, "wrap_after_lower");
        chk("lower_last_idx", bus.step_idx, 4'd0);
        ticks(4);
        bus.step_period = PW'(6);
        ticks(30);
        pulse_stop();

        // Asynchronous reset during FETCH
        bus.step_period = PW'(10);
        pulse_play();
        chk("fetch_rd_high", bus.pat_rd, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rd_low", bus.pat_rd, 1'b0);
        chk("async_running_low", bus.running, 1'b0);
        chk("async_idx_zero", bus.step_idx, 4'd0);
        ticks(2);
        reset = 1'b0;
        ticks(20);

        // Random playback
        for (int n = 0; n < 3000; n++) begin
            bus.play = ($urandom_range(19) == 0);
            bus.stop = ($urandom_range(79) == 0);
            if ($urandom_range(49) == 0) bus.step_period = PW'($urandom_range(12));
            if ($urandom_range(39) == 0) bus.last_step = 4'($urandom);
            if ($urandom_range(29) == 0) bus.mute = 4'($urandom);
            if (!m_run && $urandom_range(3) == 0) mem[$urandom_range(NUM_STEPS - 1)] = 4'($urandom);
            tick();
        end
        bus.play = 1'b0;
        bus.stop = 1'b0;
        ticks(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/step_scheduler.md
# step_scheduler

Playback controller for the step sequencer. Runs a tempo counter, walks a step index through the pattern memory, fetches each step's track bits over a one-cycle-latency read port, and emits one-cycle trigger pulses per track. It sits between the board-level user controls (KEY pulses, SW mute/length) and the pattern RAM / sound and display blocks, and is the only block that sequences reads of the pattern memory during playback.

## Interface
- NUM_STEPS, 16: pattern length capacity, power of two.
- SW_IDX, 4: step index width, equal to log2(NUM_STEPS).
- NUM_TRACKS, 4: tracks per step, one pattern bit each.
- PW, 26: width of step_period.

Ports:
- CLOCK_50  in  1  system clock; the block's only clock.
- reset  in  1  asynchronous, active-high; clears all state.
- play  in  1  single-cycle pulse; start or resume playback from IDLE.
- stop  in  1  single-cycle pulse; halt playback and rewind to step 0.
- step_period  in  PW  cycles between trigger pulses; clamped to a minimum of 4.
- last_step  in  SW_IDX  index of the final active step; the sequence wraps after it.
- mute  in  NUM_TRACKS  per-track mute; a 1 suppresses that track's trigger.
- pat_rd  out  1  pattern read strobe.
- pat_addr  out  SW_IDX  pattern read address; always equals step_idx.
- pat_data  in  NUM_TRACKS  pattern word, valid the cycle after pat_rd.
- trig  out  NUM_TRACKS  one-cycle trigger pulses.
- step_tick  out  1  one-cycle pulse, coincident with every trig update.
- step_idx  out  SW_IDX  current step, for LED/HEX display.
- running  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: stopped.
  - FETCH: pat_rd=1 for exactly one cycle.
  - LATCH: pat_data is valid.
  - COUNT: waiting out the step period.
- Transitions:
  - IDLE --play--> FETCH.
  - FETCH --> LATCH.
  - LATCH --> COUNT. On this edge: trig <= pat_data & ~mute, step_tick <= 1, cnt <= P-3.
  - COUNT with cnt != 0: cnt decrements.
  - COUNT with cnt == 0: go to FETCH and advance the step. If step_idx >= last_step, step_idx <= 0; otherwise step_idx <= step_idx+1.
- Effective period: P = max(step_period, 4), sampled only on the LATCH->COUNT edge. A step_period change takes effect from the next step.
- last_step is sampled only at advance, so lowering it below the current step wraps to 0 at the next advance. mute is sampled on the LATCH->COUNT edge.
- stop, from any state, on the next edge:
  - state -> IDLE, step_idx -> 0, cnt -> 0;
  - trig and step_tick -> 0, and any in-flight fetch is discarded.
- stop and play in the same cycle: stop wins.
- play while running: ignored.
- Reset values: state IDLE; step_idx, cnt, trig, step_tick, pat_rd and running all 0.
- pat_addr is combinationally equal to step_idx.
- pat_rd is asserted only in FETCH.

## Timing
- play sampled at edge E0:
  - FETCH in the cycle after E0 (C1);
  - LATCH in C2;
  - trig and step_tick high in C3.
- Latency from play to trig is therefore 3 cycles.
- Steady state: trig pulses are exactly P cycles apart. COUNT lasts P-2 cycles, and FETCH plus LATCH add 2.
- trig and step_tick are registered and high for exactly one cycle per step. A muted track stays 0 while step_tick still pulses.
- running rises the cycle after play is sampled and falls the cycle after stop is sampled.
- reset mid-operation: all outputs return to their reset values immediately (asynchronous). Playback resumes only on a fresh play pulse after reset deasserts.
- cnt width is PW; P-3 never underflows because P >= 4.

## Test plan
- Reset then idle:
  - Stimulus: assert reset, release it, wait 100 cycles with no play.
  - Required: trig=0, pat_rd=0, running=0, step_idx=0 throughout.
- Basic playback:
  - Stimulus: step_period=10, last_step=3, pattern {0:0001, 1:0010, 2:0100, 3:1000}, pulse play.
  - Required: trig=0001 three cycles after play, then 0010, 0100, 1000, 0001 every 10 cycles. step_idx follows 0,1,2,3,0.
- Clamp and mute:
  - Stimulus: step_period=1, mute=0001, all pattern words 1111.
  - Required: trig=1110 every 4 cycles; step_tick pulses every 4 cycles.
- Stop mid-step:
  - Stimulus: pulse stop during COUNT at step 2, then play 20 cycles later.
  - Required: running=0 and step_idx=0 one cycle after stop. Playback restarts at step 0, with trig 3 cycles after the play pulse.
- Simultaneous events and live changes:
  - Stimulus: play and stop in the same cycle. While at step 5, lower last_step to 2. Change step_period from 10 to 6 mid-step.
  - Required: the play+stop cycle leaves the block IDLE. The next advance after lowering last_step goes to step 0. The current interval stays 10 and later intervals are 6.
- Asynchronous reset during FETCH:
  - Stimulus: assert reset while pat_rd=1.
  - Required: pat_rd drops without waiting for a clock edge. No trig pulse appears after reset is released.
